eth_xmit: RTL

//  Ethernet byte-stream transmitter towards the PHY.

---
 rtl/eth_xmit.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_xmit.sv
// Ethernet byte-stream transmitter towards the PHY.
// Sends ARP replies and IPv4/UDP datagrams (payload pulled from a show-ahead FIFO):
// preamble/SFD, L2/L3/L4 headers, zero pad to the 60-byte minimum, then the FCS.
// Optional feature macro: ETH_XMIT_IFG_EN adds an IFG_BYTES-long inter-frame gap state.
// Byte outputs are registered one cycle behind the FSM state. Payload bytes bypass that
// register so that o_data follows i_pl_data in the cycles where o_pl_rd is high.
module eth_xmit #(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter int unsigned IP_TTL      = 64,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [10:0] i_pl_len,
  input  logic        i_arp_req,
  input  logic        i_udp_req,
  output logic        o_arp_ack,
  output logic        o_udp_ack,
  output logic        o_pl_rd,
  input  logic [7:0]  i_pl_data,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    StIdle,
    StPreamble,
    StDstMac,
    StSrcMac,
    StEtype,
    StArpBody,
    StIpHdr,
    StUdpHdr,
    StPayload,
    StPad,
    StFcs
`ifdef ETH_XMIT_IFG_EN
    , StIfg
`endif
  } state_e;

  localparam logic [7:0] Ttl = 8'(IP_TTL);
`ifdef ETH_XMIT_IFG_EN
  localparam logic [10:0] IfgLast = 11'(IFG_BYTES - 1);
`endif

  // One byte step of the reflected CRC-32 (poly 04C11DB7 reversed = EDB88320)
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_e      state_q;
  logic [10:0] cnt_q;
  logic        is_arp_q;
  logic [47:0] self_mac_q;
  logic [31:0] self_ip_q;
  logic [47:0] dst_mac_q;
  logic [31:0] dst_ip_q;
  logic [15:0] src_port_q;
  logic [15:0] dst_port_q;
  logic [10:0] pl_len_q;
  logic [15:0] ip_id_q;
  logic [15:0] csum_q;
  logic [31:0] crc_q;
  logic [7:0]  data_q;
  logic        data_vl_q;
  logic        pl_rd_q;
  logic        crc_en_q;
  logic        arp_ack_q;
  logic        udp_ack_q;
  logic        busy_q;

  logic        udp_ok;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [10:0] pad_len;
  logic [31:0] csum_sum;
  logic [16:0] csum_fold1;
  logic [15:0] csum_fold2;
  logic [15:0] csum_calc;
  logic [0:5][7:0]  dst_mac_b;
  logic [0:5][7:0]  src_mac_b;
  logic [0:1][7:0]  etype_b;
  logic [0:27][7:0] arp_b;
  logic [0:19][7:0] ip_b;
  logic [0:7][7:0]  udp_b;
  logic [3:0][7:0]  fcs_b;
  logic [7:0]  tx_byte;
  logic [31:0] crc_nx;
  logic [7:0]  byte_nx;
  logic [10:0] last_idx;
  state_e      state_nx;
  logic        term;
  logic        emit;
  logic        covered;

  assign udp_ok = i_udp_req && (i_pl_len != 11'd0) && (32'(i_pl_len) <= MAX_PAYLOAD);

  // Header fields and IPv4 checksum, all derived from the latched request
  always_comb begin
    tot_len    = 16'(pl_len_q) + 16'd28;
    udp_len    = 16'(pl_len_q) + 16'd8;
    pad_len    = is_arp_q ? 11'd18 : ((pl_len_q < 11'd18) ? (11'd18 - pl_len_q) : 11'd0);
    csum_sum   = 32'h0000_4500 + 32'(tot_len) + 32'(ip_id_q) + 32'h0000_4000
               + {16'h0, Ttl, 8'h11}
               + 32'(self_ip_q[31:16]) + 32'(self_ip_q[15:0])
               + 32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0]);
    csum_fold1 = 17'(csum_sum[15:0]) + 17'(csum_sum[31:16]);
    csum_fold2 = csum_fold1[15:0] + {15'h0, csum_fold1[16]};
    csum_calc  = ~csum_fold2;
    dst_mac_b  = dst_mac_q;
    src_mac_b  = self_mac_q;
    etype_b    = is_arp_q ? 16'h0806 : 16'h0800;
    arp_b      = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                  self_mac_q, self_ip_q, dst_mac_q, dst_ip_q};
    ip_b       = {16'h4500, tot_len, ip_id_q, 16'h4000, Ttl, 8'h11, csum_q,
                  self_ip_q, dst_ip_q};
    udp_b      = {src_port_q, dst_port_q, udp_len, 16'h0000};
  end

  // Byte on the wire this cycle and the CRC including it (FCS reads the result directly)
  always_comb begin
    tx_byte = pl_rd_q ? i_pl_data : data_q;
    crc_nx  = crc_en_q ? crc32_byte(crc_q, tx_byte) : crc_q;
    fcs_b   = ~crc_nx;
  end

  // Next byte, terminal count and successor state for the current FSM state
  always_comb begin
    byte_nx  = 8'h00;
    last_idx = 11'd0;
    state_nx = StIdle;
    covered  = 1'b0;
`ifdef ETH_XMIT_IFG_EN
    emit     = (state_q != StIdle) && (state_q != StIfg);
`else
    emit     = (state_q != StIdle);
`endif
    case (state_q)
      StPreamble: begin
        byte_nx  = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
        last_idx = 11'd7;
        state_nx = StDstMac;
      end
      StDstMac: begin
        byte_nx  = dst_mac_b[cnt_q[2:0]];
        last_idx = 11'd5;
        state_nx = StSrcMac;
        covered  = 1'b1;
      end
      StSrcMac: begin
        byte_nx  = src_mac_b[cnt_q[2:0]];
        last_idx = 11'd5;
        state_nx = StEtype;
        covered  = 1'b1;
      end
      StEtype: begin
        byte_nx  = etype_b[cnt_q[0]];
        last_idx = 11'd1;
        state_nx = is_arp_q ? StArpBody : StIpHdr;
        covered  = 1'b1;
      end
      StArpBody: begin
        byte_nx  = arp_b[cnt_q[4:0]];
        last_idx = 11'd27;
        state_nx = StPad;
        covered  = 1'b1;
      end
      StIpHdr: begin
        byte_nx  = ip_b[cnt_q[4:0]];
        last_idx = 11'd19;
        state_nx = StUdpHdr;
        covered  = 1'b1;
      end
      StUdpHdr: begin
        byte_nx  = udp_b[cnt_q[2:0]];
        last_idx = 11'd7;
        state_nx = StPayload;
        covered  = 1'b1;
      end
      StPayload: begin
        // Data comes straight from i_pl_data via the o_pl_rd bypass
        last_idx = pl_len_q - 11'd1;
        state_nx = (pad_len != 11'd0) ? StPad : StFcs;
        covered  = 1'b1;
      end
      StPad: begin
        last_idx = pad_len - 11'd1;
        state_nx = StFcs;
        covered  = 1'b1;
      end
      StFcs: begin
        byte_nx  = fcs_b[cnt_q[1:0]];
        last_idx = 11'd3;
`ifdef ETH_XMIT_IFG_EN
        state_nx = StIfg;
`else
        state_nx = StIdle;
`endif
      end
`ifdef ETH_XMIT_IFG_EN
      StIfg: begin
        last_idx = IfgLast;
        state_nx = StIdle;
      end
`endif
      default: begin
        state_nx = StIdle;
      end
    endcase
    term = (cnt_q == last_idx);
  end

  // Frame FSM with registered outputs, request latching, checksum and CRC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 11'd0;
      is_arp_q   <= 1'b0;
      self_mac_q <= 48'h0;
      self_ip_q  <= 32'h0;
      dst_mac_q  <= 48'h0;
      dst_ip_q   <= 32'h0;
      src_port_q <= 16'h0;
      dst_port_q <= 16'h0;
      pl_len_q   <= 11'd0;
      ip_id_q    <= 16'h0;
      csum_q     <= 16'h0;
      crc_q      <= 32'hFFFF_FFFF;
      data_q     <= 8'h00;
      data_vl_q  <= 1'b0;
      pl_rd_q    <= 1'b0;
      crc_en_q   <= 1'b0;
      arp_ack_q  <= 1'b0;
      udp_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      arp_ack_q <= 1'b0;
      udp_ack_q <= 1'b0;
      data_q    <= byte_nx;
      data_vl_q <= emit;
      pl_rd_q   <= (state_q == StPayload);
      crc_en_q  <= covered;
      crc_q     <= crc_nx;
      if (state_q == StIdle) begin
        cnt_q <= 11'd0;
        if (i_arp_req || udp_ok) begin
          // ARP wins when both are pending
          is_arp_q   <= i_arp_req;
          arp_ack_q  <= i_arp_req;
          udp_ack_q  <= ~i_arp_req;
          self_mac_q <= i_self_mac;
          self_ip_q  <= i_self_ip;
          dst_mac_q  <= i_dst_mac;
          dst_ip_q   <= i_dst_ip;
          src_port_q <= i_src_port;
          dst_port_q <= i_dst_port;
          pl_len_q   <= i_pl_len;
          busy_q     <= 1'b1;
          state_q    <= StPreamble;
        end else begin
          busy_q <= 1'b0;
        end
      end else begin
        if (term) begin
          state_q <= state_nx;
          cnt_q   <= 11'd0;
        end else begin
          cnt_q <= cnt_q + 11'd1;
        end
        if (state_q == StPreamble) begin
          crc_q  <= 32'hFFFF_FFFF;
          csum_q <= csum_calc;
        end
        // IP header already sent; bump the id for the next datagram
        if ((state_q == StUdpHdr) && term) begin
          ip_id_q <= ip_id_q + 16'd1;
        end
      end
    end
  end

  assign o_arp_ack = arp_ack_q;
  assign o_udp_ack = udp_ack_q;
  assign o_pl_rd   = pl_rd_q;
  assign o_data    = tx_byte;
  assign o_data_vl = data_vl_q;
  assign o_busy    = busy_q;

endmodule
